// File: rtl/spi_flash_reader_if.sv
// Request/response bus between the memory fabric and the SPI flash reader.
// master drives requests; slave is the controller side.
interface spi_flash_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/spi_flash_reader.sv
// Read-only SPI NOR flash controller: one 32-bit little-endian word per request.
// Define SPI_FLASH_DUAL_READ_EN for dual-output read (0x3B, 8 dummy clocks, 2 bits/clock).
module spi_flash_reader #(
  parameter int CLK_DIV = 1,
  parameter int CS_HIGH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  spi_flash_reader_if.slave bus,
  output logic              flash_clk,
  output logic              flash_csn,
  output logic              flash_io0_en,
  output logic              flash_io0_out,
  input  logic              flash_io0_in,
  output logic              flash_io1_en,
  output logic              flash_io1_out,
  input  logic              flash_io1_in
);

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [3:0] CS_LAST   = 4'(CS_HIGH - 1);
  localparam logic [5:0] CMD_LAST  = 6'd7;
  localparam logic [5:0] ADDR_LAST = 6'd31;

`ifdef SPI_FLASH_DUAL_READ_EN
  localparam logic [7:0] CMD_BYTE   = 8'h3B;
  localparam logic [5:0] DUMMY_LAST = 6'd39;
  localparam logic [5:0] DATA_LAST  = 6'd55;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE, S_CS_WAIT
  } state_t;
`else
  localparam logic [7:0] CMD_BYTE  = 8'h03;
  localparam logic [5:0] DATA_LAST = 6'd63;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE, S_CS_WAIT
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        sclk_q, sclk_d;
  logic        csn_q, csn_d;
  logic        en_q, en_d;
  logic        mosi_q, mosi_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [5:0]  idx_q, idx_d;
  logic [3:0]  cs_cnt_q, cs_cnt_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic        busy_s;
  logic        tick_s;
  logic        bit_end_s;
  logic [31:0] rx_shift_s;

  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign tick_s    = (div_q == DIV_LAST);
  assign bit_end_s = tick_s && sclk_q;

`ifdef SPI_FLASH_DUAL_READ_EN
  assign busy_s     = (state_q == S_CMD) || (state_q == S_ADDR) ||
                      (state_q == S_DUMMY) || (state_q == S_DATA);
  assign rx_shift_s = {rx_q[29:0], flash_io1_in, flash_io0_in};
`else
  logic unused_io0_s;
  assign unused_io0_s = flash_io0_in;
  assign busy_s       = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign rx_shift_s   = {rx_q[30:0], flash_io1_in};
`endif

  // Next-state and next-output logic; every pin is registered from here.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    sclk_d      = sclk_q;
    csn_d       = csn_q;
    en_d        = en_q;
    mosi_d      = mosi_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    idx_d       = idx_q;
    cs_cnt_d    = cs_cnt_q;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    if (busy_s) begin
      if (tick_s) begin
        div_d  = 8'd0;
        sclk_d = ~sclk_q;
      end else begin
        div_d  = div_q + 8'd1;
      end
    end else begin
      div_d = div_q;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && ready_q) begin
          state_d = S_CMD;
          csn_d   = 1'b0;
          en_d    = 1'b1;
          sclk_d  = 1'b0;
          div_d   = 8'd0;
          idx_d   = 6'd0;
          mosi_d  = CMD_BYTE[7];
          tx_d    = {CMD_BYTE[6:0], bus.req_addr, 1'b0};
        end else begin
          ready_d = 1'b1;
        end
      end
      S_CMD: begin
        if (bit_end_s) begin
          idx_d  = idx_q + 6'd1;
          mosi_d = tx_q[31];
          tx_d   = {tx_q[30:0], 1'b0};
          if (idx_q == CMD_LAST) begin
            state_d = S_ADDR;
          end else begin
            state_d = S_CMD;
          end
        end else begin
          state_d = S_CMD;
        end
      end
      S_ADDR: begin
        if (bit_end_s) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == ADDR_LAST) begin
            // io0 is released as the first post-address low phase begins.
            en_d   = 1'b0;
            mosi_d = 1'b0;
`ifdef SPI_FLASH_DUAL_READ_EN
            state_d = S_DUMMY;
`else
            state_d = S_DATA;
`endif
          end else begin
            mosi_d = tx_q[31];
            tx_d   = {tx_q[30:0], 1'b0};
          end
        end else begin
          state_d = S_ADDR;
        end
      end
`ifdef SPI_FLASH_DUAL_READ_EN
      S_DUMMY: begin
        if (bit_end_s) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == DUMMY_LAST) begin
            state_d = S_DATA;
          end else begin
            state_d = S_DUMMY;
          end
        end else begin
          state_d = S_DUMMY;
        end
      end
`endif
      S_DATA: begin
        if (bit_end_s) begin
          idx_d = idx_q + 6'd1;
          rx_d  = rx_shift_s;
          if (idx_q == DATA_LAST) begin
            state_d = S_DONE;
            csn_d   = 1'b1;
            sclk_d  = 1'b0;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = swap_bytes(rx_q);
        cs_cnt_d    = 4'd0;
        state_d     = S_CS_WAIT;
      end
      S_CS_WAIT: begin
        if (cs_cnt_q == CS_LAST) begin
          cs_cnt_d = 4'd0;
          ready_d  = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cs_cnt_d = cs_cnt_q + 4'd1;
          state_d  = S_CS_WAIT;
        end
      end
      default: begin
        state_d  = S_CS_WAIT;
        csn_d    = 1'b1;
        sclk_d   = 1'b0;
        en_d     = 1'b0;
        mosi_d   = 1'b0;
        cs_cnt_d = 4'd0;
      end
    endcase
  end

  // State and output registers; reset releases the flash bus immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_CS_WAIT;
      div_q       <= 8'd0;
      sclk_q      <= 1'b0;
      csn_q       <= 1'b1;
      en_q        <= 1'b0;
      mosi_q      <= 1'b0;
      tx_q        <= 32'd0;
      rx_q        <= 32'd0;
      idx_q       <= 6'd0;
      cs_cnt_q    <= 4'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      sclk_q      <= sclk_d;
      csn_q       <= csn_d;
      en_q        <= en_d;
      mosi_q      <= mosi_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      idx_q       <= idx_d;
      cs_cnt_q    <= cs_cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign flash_clk     = sclk_q;
  assign flash_csn     = csn_q;
  assign flash_io0_en  = en_q;
  assign flash_io0_out = mosi_q;
  assign flash_io1_en  = 1'b0;
  assign flash_io1_out = 1'b0;

endmodule
